debounce_bank: RTL and testbench
================================

# debounce_bank

Parametrised multi-channel switch debouncer for the microwave front panel: keypad columns, start/stop buttons and door switch. Each channel optionally synchronises its raw input, then requires the input to hold a new level for a configurable number of consecutive clock cycles before the clean level changes. On every accepted change it emits one-cycle rise and fall pulses. It sits between the board pins and the encoder/controller logic, replacing single-channel, edge-triggered debouncing with one fully synchronous block.

## Interface
Parameters:
- N_CH, 4: number of independent channels; must be ≥1.
- STABLE_CYCLES, 8: consecutive cycles of a new level required before acceptance; must be ≥2.
- RESET_LEVEL, 1'b0: level loaded into every channel's clean output and synchroniser on reset.
- CNT_W, $clog2(STABLE_CYCLES+1): counter width; derived, never overridden.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- raw_in  in  N_CH  raw switch levels, asynchronous to clk.
- clear  in  1  synchronous; aborts all pending counts.
- level_out  out  N_CH  debounced level per channel.
- rise_out  out  N_CH  one-cycle pulse when a channel's level_out goes 0→1.
- fall_out  out  N_CH  one-cycle pulse when a channel's level_out goes 1→0.
- any_event  out  1  OR of all rise_out and fall_out bits, registered with them.

## Operation
- Reset values: level_out = {N_CH{RESET_LEVEL}}; synchroniser flops = RESET_LEVEL; counters = 0; rise_out, fall_out and any_event = 0.
- Per channel, s is the sampled input: the synchroniser output, or raw_in[i] directly (see Configuration).
- Each rising edge, per channel, in priority order:
  1. clear=1: cnt←0; no toggle; no pulse.
  2. Else s == level_out[i]: cnt←0.
  3. Else cnt == STABLE_CYCLES-1: level_out[i]←s; cnt←0; pulse rise_out[i] or fall_out[i] for the next cycle only.
  4. Else: cnt←cnt+1.
- A bounce returning to the current level before acceptance discards the count (rule 2). There is no partial credit.
- Counter never exceeds STABLE_CYCLES-1. No wrap-around is possible.
- Channels are fully independent. Any number may toggle on the same edge, each producing its own pulse.
- clear and an accepting edge coinciding: clear wins; no toggle that cycle.
- Reset mid-count: immediate return to reset values. No pulse is generated by reset deassertion.

## Timing
- With synchroniser: a raw change held stable from edge 1 (the capturing edge) updates level_out at edge STABLE_CYCLES+2. The pulse is high during the following cycle.
- Without synchroniser: level_out updates at edge STABLE_CYCLES.
- rise_out, fall_out and any_event are registered and high for exactly one cycle, coincident with the first cycle of the new level_out.
- Minimum spacing between two accepted changes on one channel is STABLE_CYCLES cycles.
- No combinational path from any input to any output.

## Configuration
- DEBOUNCE_BANK_SYNC_EN defined: a two-flop synchroniser per channel (reset to RESET_LEVEL) precedes the counter. Latency is STABLE_CYCLES+2.
- Not defined: the synchroniser is omitted. raw_in must already be synchronous to clk, and latency is STABLE_CYCLES.
- Pulse width and all priority rules are identical in both builds.

## Structure
- Package debounce_pkg holds:
  - the default constants DB_STABLE_CYCLES_DEF=8 and DB_RESET_LEVEL_DEF=1'b0;
  - the function computing CNT_W.
- Sub-module debounce_ch implements one channel: synchroniser, counter, level register and pulse registers.
- debounce_bank instantiates N_CH copies in a generate loop and ORs their pulses into any_event.

## Test plan
All scenarios use N_CH=4, STABLE_CYCLES=8, RESET_LEVEL=0, and a build with DEBOUNCE_BANK_SYNC_EN defined.
- Clean press: raw_in[0] 0→1 held 20 cycles → level_out[0]=1 at edge 10; rise_out[0] and any_event high for 1 cycle; other channels unchanged.
- Bounce: raw_in[1] toggles high for 5 cycles, low for 2, then high for 12 → a single rise, at the 10th edge after the final rising transition; no pulse for the 5-cycle glitch.
- Simultaneous: raw_in=4'b1111 on one edge → all level_out bits rise on the same edge; rise_out=4'b1111 for one cycle; any_event=1 for one cycle.
- Clear priority: assert clear on the edge where channel 2's cnt==7 → no toggle; a stable input re-accepts 8 edges later.
- Reset mid-count: rst_n low at cnt=5 with level_out[3]=1 → all outputs 0 immediately; no pulse after deassertion with raw_in=0.
- Release: raw_in[0] 1→0 held → fall_out[0] pulses one cycle; rise_out[0] stays 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and counter-width helper for the debounce bank
package debounce_pkg;
  localparam int DB_STABLE_CYCLES_DEF = 8;
  localparam logic DB_RESET_LEVEL_DEF = 1'b0;
  function automatic int db_cnt_w(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one debounced channel; DEBOUNCE_BANK_SYNC_EN adds a two-flop input synchroniser
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter logic RESET_LEVEL = DB_RESET_LEVEL_DEF,
  parameter int CNT_W = db_cnt_w(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clear,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s;
  logic accept;
  logic [CNT_W-1:0] cnt;
`ifdef DEBOUNCE_BANK_SYNC_EN
  logic [1:0] sync;
  // two-flop synchroniser for the asynchronous pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {2{RESET_LEVEL}};
    else sync <= {sync[0], raw};
  end
  assign s = sync[1];
`else
  assign s = raw;
`endif
  assign accept = !clear && (s != level) && (cnt == CNT_W'(STABLE_CYCLES - 1));
  // stability counter, clean level and one-cycle change pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt  <= (clear || s == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? s : level;
      rise <= accept && s;
      fall <= accept && !s;
    end
  end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent switch debouncers; DEBOUNCE_BANK_SYNC_EN enables input synchronisers
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
  parameter logic RESET_LEVEL = DB_RESET_LEVEL_DEF,
  parameter int CNT_W = db_cnt_w(STABLE_CYCLES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_in,
  input  logic            clear,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic            any_event
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_LEVEL(RESET_LEVEL),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw(raw_in[i]),
      .clear(clear),
      .level(level_out[i]),
      .rise(rise_out[i]),
      .fall(fall_out[i])
    );
  end
  // pulses are already registered, so the OR stays coincident with them
  assign any_event = |(rise_out | fall_out);
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench for debounce_bank (N_CH=4, STABLE_CYCLES=8)
module tb_debounce_bank;
  localparam int N = 4;
`ifdef DEBOUNCE_BANK_SYNC_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 8;
`endif
  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] raw_in;
  logic clear;
  logic [N-1:0] level_out, rise_out, fall_out;
  logic any_event;
  exp_t q[$];
  exp_t e;
  int cmp = 0;
  int mism = 0;

  debounce_bank #(.N_CH(N), .STABLE_CYCLES(8), .RESET_LEVEL(1'b0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .raw_in(raw_in),
    .clear(clear),
    .level_out(level_out),
    .rise_out(rise_out),
    .fall_out(fall_out),
    .any_event(any_event)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [N-1:0] lvl, input logic [N-1:0] rise, input logic [N-1:0] fall);
    return '{lvl: lvl, rise: rise, fall: fall, any: |(rise | fall)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw_in = '0;
    clear = 1'b0;
    #1;
    cmp++;
    if ({level_out, rise_out, fall_out, any_event} !== 13'b0) begin
      mism++;
      $display("FAIL reset_async: got %b_%b_%b_%b want all zero", level_out, rise_out, fall_out, any_event);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) q.push_back(mk(4'b0000, 4'b0000, 4'b0000));
    for (int k = 1; k <= 3; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL reset_release edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  task automatic test_clean_press();
    raw_in[0] = 1'b1;
    for (int k = 1; k <= 20; k++)
      q.push_back(mk(k >= LAT ? 4'b0001 : 4'b0000, k == LAT ? 4'b0001 : 4'b0000, 4'b0000));
    for (int k = 1; k <= 20; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL clean_press edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  task automatic test_release();
    raw_in[0] = 1'b0;
    for (int k = 1; k <= LAT + 4; k++)
      q.push_back(mk(k >= LAT ? 4'b0000 : 4'b0001, 4'b0000, k == LAT ? 4'b0001 : 4'b0000));
    for (int k = 1; k <= LAT + 4; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL release edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 19; k++) begin
      raw_in[1] = (k <= 5) ? 1'b1 : (k <= 7) ? 1'b0 : 1'b1;
      q.push_back(mk(k >= 7 + LAT ? 4'b0010 : 4'b0000, k == 7 + LAT ? 4'b0010 : 4'b0000, 4'b0000));
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL bounce edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
    raw_in[1] = 1'b0;
    for (int k = 1; k <= LAT + 2; k++)
      q.push_back(mk(k >= LAT ? 4'b0000 : 4'b0010, 4'b0000, k == LAT ? 4'b0010 : 4'b0000));
    for (int k = 1; k <= LAT + 2; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL bounce_release edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    raw_in = 4'b1111;
    for (int k = 1; k <= LAT + 3; k++)
      q.push_back(mk(k >= LAT ? 4'b1111 : 4'b0000, k == LAT ? 4'b1111 : 4'b0000, 4'b0000));
    for (int k = 1; k <= LAT + 3; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL simultaneous edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  task automatic test_clear_priority();
    raw_in[2] = 1'b0;
    for (int k = 1; k <= LAT + 10; k++) begin
      clear = (k == LAT);
      q.push_back(mk(k >= LAT + 8 ? 4'b1011 : 4'b1111, 4'b0000, k == LAT + 8 ? 4'b0100 : 4'b0000));
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL clear_priority edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    raw_in = 4'b0000;
    for (int k = 1; k <= LAT - 3; k++) q.push_back(mk(4'b1011, 4'b0000, 4'b0000));
    for (int k = 1; k <= LAT - 3; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL mid_count_hold edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({level_out, rise_out, fall_out, any_event} !== 13'b0) begin
      mism++;
      $display("FAIL mid_count_reset: got %b_%b_%b_%b want all zero", level_out, rise_out, fall_out, any_event);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) q.push_back(mk(4'b0000, 4'b0000, 4'b0000));
    for (int k = 1; k <= 12; k++) begin
      step();
      e = q.pop_front();
      cmp++;
      if ({level_out, rise_out, fall_out, any_event} !== e) begin
        mism++;
        $display("FAIL post_reset edge %0d: got %b_%b_%b_%b want %b", k, level_out, rise_out, fall_out, any_event, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_clear_priority();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
